// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : line_mem_responder
// Purpose  : In-order 128-bit cache-line memory responder with request FIFO,
//            fixed access latency and read-response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
  parameter int ADDRWIDTH = 27,
  parameter int LINEWIDTH = 13,
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_en,
  output logic                 req_rdy,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [127:0]         req_data,
  input  logic                 req_cmd,
  output logic                 rsp_en,
  input  logic                 rsp_rdy,
  output logic [127:0]         rsp_data
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_ptr_w:0]   c_depth  = (c_ptr_w+1)'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_lat_m1 = c_cnt_w'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  logic [LINEWIDTH-1:0] r_fifo_line [DEPTH];
  logic [127:0]         r_fifo_data [DEPTH];
  logic                 r_fifo_cmd  [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 r_rdy_en;

  logic [127:0]         r_ram [2**LINEWIDTH];

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [LINEWIDTH-1:0] r_line;
  logic [127:0]         r_data;
  logic                 r_cmd;
  logic                 r_rsp_en;
  logic [127:0]         r_rsp_data;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_ram_we;
  logic                 w_unused_addr;

  // Reserved/offset address bits carry no meaning for the line RAM.
  assign w_unused_addr = ^{req_addr[ADDRWIDTH-1:3+LINEWIDTH], req_addr[2:0]};

  // r_rdy_en keeps req_rdy low while reset is asserted.
  assign req_rdy  = r_rdy_en && (r_count != c_depth);
  assign w_push   = req_en && req_rdy;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  assign w_ram_we = (r_state == S_ACCESS) && (r_cnt == '0) && !r_cmd;
  assign rsp_en   = r_rsp_en;
  assign rsp_data = r_rsp_data;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_line[r_wr_ptr] <= req_addr[3 +: LINEWIDTH];
      r_fifo_data[r_wr_ptr] <= req_data;
      r_fifo_cmd[r_wr_ptr]  <= req_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[r_line] <= r_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_line     <= '0;
      r_data     <= '0;
      r_cmd      <= 1'b0;
      r_rsp_en   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_line  <= r_fifo_line[r_rd_ptr];
            r_data  <= r_fifo_data[r_rd_ptr];
            r_cmd   <= r_fifo_cmd[r_rd_ptr];
            r_cnt   <= c_lat_m1;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_cmd) begin
            r_rsp_data <= r_ram[r_line];
            r_rsp_en   <= 1'b1;
            r_state    <= S_RESPOND;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RESPOND: begin
          if (rsp_rdy) begin
            r_rsp_en <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_mem_responder
// Purpose  : Self-checking bench: line-memory reference model and ordered
//            expected-response queue for line_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

  localparam int AW  = 27;
  localparam int LW  = 13;
  localparam int DEP = 4;

  logic          clk      = 1'b0;
  logic          rstn     = 1'b0;
  logic          req_en   = 1'b0;
  logic          req_en1  = 1'b0;
  logic          req_cmd  = 1'b0;
  logic          rsp_rdy  = 1'b0;
  logic          rsp_rdy1 = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [127:0]  req_data = '0;
  logic          req_rdy, rsp_en, req_rdy1, rsp_en1;
  logic [127:0]  rsp_data, rsp_data1;

  always #5 clk = ~clk;

  line_mem_responder #(.ADDRWIDTH(AW), .LINEWIDTH(LW), .DEPTH(DEP), .LATENCY(2)) u_dut (
    .clk(clk), .rstn(rstn), .req_en(req_en), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_data(req_data), .req_cmd(req_cmd), .rsp_en(rsp_en), .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data));

  line_mem_responder #(.ADDRWIDTH(AW), .LINEWIDTH(LW), .DEPTH(DEP), .LATENCY(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .req_en(req_en1), .req_rdy(req_rdy1), .req_addr(req_addr),
    .req_data(req_data), .req_cmd(req_cmd), .rsp_en(rsp_en1), .rsp_rdy(rsp_rdy1),
    .rsp_data(rsp_data1));

  int           n_checks = 0;
  int           n_fails  = 0;
  int           n_rsp    = 0;
  int           n_acc    = 0;
  logic [127:0] mem [int];
  logic [127:0] exp_q [$];
  logic         prev_wait = 1'b0;
  logic [127:0] prev_data = '0;
  logic         rnd_rdy   = 1'b0;
  logic         hs        = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    int line;
    @(negedge clk);
    hs = 1'b0;
    if (rstn) begin
      if (req_en && req_rdy) begin
        hs = 1'b1;
        n_acc++;
        line = int'(req_addr[3 +: LW]);
        if (req_cmd) exp_q.push_back(mem.exists(line) ? mem[line] : 128'(0));
        else         mem[line] = req_data;
      end
      if (rsp_en && prev_wait) check("rsp_hold", rsp_data, prev_data);
      if (rsp_en && rsp_rdy) begin
        n_rsp++;
        if (exp_q.size() == 0) check("unexp_rsp", 128'(rsp_en), 128'(0));
        else                   check("rsp_data", rsp_data, exp_q.pop_front());
      end
      prev_wait = rsp_en && !rsp_rdy;
      prev_data = rsp_data;
    end else begin
      prev_wait = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) rsp_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic cmd, input int line, input logic [127:0] data, input bit junk);
    req_cmd  = cmd;
    req_data = data;
    req_addr = '0;
    req_addr[3 +: LW] = LW'(line);
    if (junk) begin
      req_addr[AW-1] = 1'($urandom);
      req_addr[2:0]  = 3'($urandom);
    end
    req_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (hs) break;
    end
    if (!hs) check("req_timeout", 128'(hs), 128'(1));
    req_en = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 500) begin
      tick();
      i++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'(0));
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a5, x, y, z;
    int           f0, f1, base, base_acc;
    a5 = {16{8'hA5}};

    // Reset with a read presented: nothing may be accepted.
    req_en = 1'b1; req_en1 = 1'b1; req_cmd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", 128'(req_rdy), 128'(0));
    check("rst_req_rdy1", 128'(req_rdy1), 128'(0));
    check("rst_rsp_en", 128'(rsp_en), 128'(0));
    check("rst_rsp_data", rsp_data, 128'(0));
    rstn = 1'b1; req_en = 1'b0; req_en1 = 1'b0;
    tick();
    check("rel_req_rdy", 128'(req_rdy), 128'(1));
    check("rel_req_rdy1", 128'(req_rdy1), 128'(1));

    // Write line 5 on both instances, then timed read.
    req_en1 = 1'b1;
    send(1'b0, 5, a5, 1'b0);
    req_en1 = 1'b0;
    repeat (6) tick();
    rsp_rdy = 1'b0; rsp_rdy1 = 1'b0;
    req_cmd = 1'b1; req_addr = '0; req_addr[3 +: LW] = LW'(5);
    req_en = 1'b1; req_en1 = 1'b1;
    tick();
    check("lat_accept", 128'(hs), 128'(1));
    req_en = 1'b0; req_en1 = 1'b0;
    f0 = -1; f1 = -1;
    for (int c = 1; c < 12; c++) begin
      if (rsp_en  && f0 < 0) f0 = c;
      if (rsp_en1 && f1 < 0) f1 = c;
      tick();
    end
    check("lat_l2", 128'(f0), 128'(4));
    check("lat_l1", 128'(f1), 128'(3));
    check("l1_data", rsp_data1, a5);
    base = n_rsp;
    rsp_rdy = 1'b1; rsp_rdy1 = 1'b1;
    drain();
    check("rd_rsp_count", 128'(n_rsp - base), 128'(1));

    // Back-pressure: fill the FIFO behind a stalled response.
    for (int i = 0; i < 6; i++) send(1'b0, 'h20 + i, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (30) tick();
    rsp_rdy = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 5; i++) send(1'b1, 'h20 + i, '0, 1'b0);
    repeat (4) tick();
    check("full_rdy", 128'(req_rdy), 128'(0));
    base_acc = n_acc;
    req_cmd = 1'b1; req_addr = '0; req_addr[3 +: LW] = LW'('h25); req_en = 1'b1;
    repeat (4) tick();
    check("full_no_acc", 128'(n_acc - base_acc), 128'(0));
    req_en = 1'b0;
    rsp_rdy = 1'b1;
    drain();
    check("bp_rsp_count", 128'(n_rsp - base), 128'(5));
    check("bp_rdy_after", 128'(req_rdy), 128'(1));

    // Ordering: write/read/write/read to one line.
    x = {$urandom, $urandom, $urandom, $urandom};
    y = {$urandom, $urandom, $urandom, $urandom};
    base = n_rsp;
    send(1'b0, 'h10, x, 1'b0);
    send(1'b1, 'h10, '0, 1'b0);
    send(1'b0, 'h10, y, 1'b0);
    send(1'b1, 'h10, '0, 1'b0);
    drain();
    check("order_rsp_count", 128'(n_rsp - base), 128'(2));

    // Wrap-around and random traffic with random back-pressure and junk address bits.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 3 * DEP; i++) begin
      send(1'b0, i, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      send(1'b1, i, '0, 1'b1);
    end
    drain();
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom), $urandom_range(0, 3 * DEP - 1), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_rdy = 1'b0;
    rsp_rdy = 1'b1;
    drain();

    // Reset during RESPOND with two reads still queued.
    z = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, 'h30, z, 1'b0);
    repeat (8) tick();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 'h30, '0, 1'b0);
    repeat (3) tick();
    check("pre_rst_respond", 128'(rsp_en), 128'(1));
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_rsp_en", 128'(rsp_en), 128'(0));
    check("mid_rst_req_rdy", 128'(req_rdy), 128'(0));
    exp_q.delete();
    prev_wait = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    check("post_rst_req_rdy", 128'(req_rdy), 128'(1));
    rsp_rdy = 1'b1;
    base = n_rsp;
    repeat (10) tick();
    check("no_stale_rsp", 128'(n_rsp - base), 128'(0));
    send(1'b1, 'h30, '0, 1'b0);
    drain();
    check("post_rst_rsp_count", 128'(n_rsp - base), 128'(1));

    check("final_queue", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
